// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage, serving loads/stores from an internal word RAM.
// Optional build macro DMEM_ERR_CHECK_EN adds misalignment/range/dual-strobe checking with a sticky mem_err.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] MemWrite_data_in,
  output logic [31:0] mem_rd_data,
  output logic        mem_done,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: the pipeline presents a request (MemRead_in|MemWrite_in) and must hold it
  // unchanged while mem_stall=1; the access is complete in the cycle mem_done=1 (mem_stall=0),
  // after which the pipeline advances and the held request is never accepted a second time.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_flag;

  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_is_wr;
  logic                  r_is_rd;
  logic                  r_flag;
  logic [31:0]           r_rd_data;
  logic [31:0]           r_mem [0:DEPTH-1];

  assign w_req       = MemRead_in | MemWrite_in;
  assign o_dbg_state = r_state;
  assign mem_rd_data = r_rd_data;

`ifdef DMEM_ERR_CHECK_EN
  logic r_err;

  assign w_flag  = (|mem_addr_in[1:0])
                 | (|(mem_addr_in >> (DEPTH_LOG2 + 2)))
                 | (MemRead_in & MemWrite_in);
  assign mem_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_commit && r_flag) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_addr;

  // Without checking, upper and byte-offset address bits simply drop out of the index.
  assign w_unused_addr = ^{mem_addr_in[31:DEPTH_LOG2+2], mem_addr_in[1:0]};
  assign w_flag        = 1'b0;
  assign mem_err       = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    mem_stall  = 1'b0;
    mem_done   = 1'b0;
    w_accept   = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_stall = w_req;
        if (w_req) begin
          w_accept   = 1'b1;
          w_next     = S_ACCESS;
          w_cnt_next = 4'(WAIT_CYCLES - 1);
        end
      end
      S_ACCESS: begin
        mem_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next   = S_DONE;
          w_commit = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        // Inputs still show the request just served; always return to IDLE without relaunching.
        mem_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Both strobes set is handled as a store; the read strobe is then ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_is_wr <= 1'b0;
      r_is_rd <= 1'b0;
      r_flag  <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= mem_addr_in[DEPTH_LOG2+1:2];
      r_wdata <= MemWrite_data_in;
      r_is_wr <= MemWrite_in;
      r_is_rd <= MemRead_in & ~MemWrite_in;
      r_flag  <= w_flag;
    end
  end

  // RAM is not reset; an aborted access never reaches its commit edge because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (w_commit && r_is_wr && !r_flag) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 32'd0;
    end else if (w_commit && r_is_rd && !r_flag) begin
      r_rd_data <= r_mem[r_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a transaction-level memory model predicts per-cycle
// stall/done/read-data/error, and literal expectations pin the headline scenarios.
module tb_dmem_responder;

  localparam int D = 10;
  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [31:0] mem_addr_in;
  logic [31:0] MemWrite_data_in;
  logic [31:0] mem_rd_data;
  logic        mem_done;
  logic        mem_stall;
  logic        mem_err;
  logic [1:0]  dbg_state;

  dmem_responder #(.DEPTH_LOG2(D), .WAIT_CYCLES(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .MemRead_in       (MemRead_in),
    .MemWrite_in      (MemWrite_in),
    .mem_addr_in      (mem_addr_in),
    .MemWrite_data_in (MemWrite_data_in),
    .mem_rd_data      (mem_rd_data),
    .mem_done         (mem_done),
    .mem_stall        (mem_stall),
    .mem_err          (mem_err),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [31:0] mem_m   [0:(1<<D)-1];
  logic        known_m [0:(1<<D)-1];
  logic        exp_stall;
  logic        exp_done;
  logic [31:0] exp_rd;
  logic        exp_err;
  logic        rd_dc;
  logic        chk_en;
  int          checks;
  int          errors;
  int          done_cnt;
  int          stall_cnt;
  int          exp_done_cnt;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic flagged(input logic rd, input logic wr, input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a[1:0] != 2'd0) || ((a >> (D + 2)) != 32'd0) || (rd && wr);
`else
    return 1'b0;
`endif
  endfunction

  // Transaction-level effect of one completed access on the model.
  task automatic model_commit(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d);
    int idx;
    idx = int'(a[D+1:2]);
    if (flagged(rd, wr, a)) begin
      exp_err = 1'b1;
    end else if (wr) begin
      mem_m[idx]   = d;
      known_m[idx] = 1'b1;
    end else if (rd) begin
      exp_rd = mem_m[idx];
      rd_dc  = !known_m[idx];
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check32("stall", {31'd0, mem_stall}, {31'd0, exp_stall});
      check32("done",  {31'd0, mem_done},  {31'd0, exp_done});
      check32("err",   {31'd0, mem_err},   {31'd0, exp_err});
      if (!rd_dc) check32("rd_data", mem_rd_data, exp_rd);
      if (mem_done)  done_cnt++;
      if (mem_stall) stall_cnt++;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      MemRead_in  = 1'b0;
      MemWrite_in = 1'b0;
      exp_stall   = 1'b0;
      exp_done    = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k <= W + 1; k++) begin
      MemRead_in       = rd;
      MemWrite_in      = wr;
      mem_addr_in      = a;
      MemWrite_data_in = d;
      exp_stall        = (k <= W);
      exp_done         = (k == W + 1);
      if (k == W + 1) begin
        model_commit(rd, wr, a, d);
        exp_done_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int s0;
    logic [31:0] rd_before;
    checks = 0; errors = 0; done_cnt = 0; stall_cnt = 0; exp_done_cnt = 0;
    chk_en = 1'b0; rd_dc = 1'b0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_rd = 32'd0; exp_err = 1'b0;
    for (int i = 0; i < (1 << D); i++) known_m[i] = 1'b0;
    rst = 1'b1; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    mem_addr_in = 32'd0; MemWrite_data_in = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check32("reset_rd",    mem_rd_data, 32'd0);
    check32("reset_done",  {31'd0, mem_done},  32'd0);
    check32("reset_stall", {31'd0, mem_stall}, 32'd0);
    check32("reset_err",   {31'd0, mem_err},   32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Store then load of 0x10.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    s0 = stall_cnt;
    access(1'b1, 1'b0, 32'h10, 32'h0);
    check32("t1_load_data",   mem_rd_data, 32'hDEADBEEF);
    check32("t1_stall_cycles", 32'(stall_cnt - s0), 32'd3);
    idle(1);

    // Seed known locations, back-to-back.
    access(1'b0, 1'b1, 32'h00, 32'h0000_0000);
    access(1'b0, 1'b1, 32'h08, 32'h0000_0011);
    access(1'b0, 1'b1, 32'h20, 32'h2020_0020);
    access(1'b0, 1'b1, 32'h24, 32'h2424_0024);
    access(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D);

    // Back-to-back loads with request held through stall.
    d0 = done_cnt;
    access(1'b1, 1'b0, 32'h20, 32'h0);
    check32("t2_first_data", mem_rd_data, 32'h2020_0020);
    access(1'b1, 1'b0, 32'h24, 32'h0);
    idle(2);
    check32("t2_done_pulses", 32'(done_cnt - d0), 32'd2);
    check32("t2_second_data", mem_rd_data, 32'h2424_0024);

    // Reset during ACCESS of a store to 0x40.
    MemRead_in = 1'b0; MemWrite_in = 1'b1;
    mem_addr_in = 32'h40; MemWrite_data_in = 32'h0000_1234;
    exp_stall = 1'b1; exp_done = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b1; MemWrite_in = 1'b0;
    #1;
    check32("t3_rst_stall", {31'd0, mem_stall}, 32'd0);
    check32("t3_rst_done",  {31'd0, mem_done},  32'd0);
    check32("t3_rst_rd",    mem_rd_data, 32'd0);
    check32("t3_rst_err",   {31'd0, mem_err},   32'd0);
    exp_rd = 32'd0; exp_err = 1'b0; exp_stall = 1'b0; rd_dc = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    access(1'b1, 1'b0, 32'h40, 32'h0);
    check32("t3_old_value", mem_rd_data, 32'h0BAD_F00D);

    // Out-of-range store 0x1000 then load 0x0.
    access(1'b0, 1'b1, 32'h1000, 32'hA5A5_A5A5);
    access(1'b1, 1'b0, 32'h0, 32'h0);
`ifdef DMEM_ERR_CHECK_EN
    check32("t4_err",     {31'd0, mem_err}, 32'd1);
    check32("t4_ram0",    mem_rd_data, 32'h0000_0000);
`else
    check32("t4_err",     {31'd0, mem_err}, 32'd0);
    check32("t4_wrap",    mem_rd_data, 32'hA5A5_A5A5);
`endif

    // Misaligned load 0x12.
    rd_before = mem_rd_data;
    access(1'b1, 1'b0, 32'h12, 32'h0);
`ifdef DMEM_ERR_CHECK_EN
    check32("t5_err",  {31'd0, mem_err}, 32'd1);
    check32("t5_keep", mem_rd_data, rd_before);
`else
    check32("t5_load", mem_rd_data, 32'hDEADBEEF);
`endif

    // Both strobes: behaves as a store, read data untouched.
    rd_before = mem_rd_data;
    access(1'b1, 1'b1, 32'h08, 32'h0000_0055);
    check32("t6_rd_keep", mem_rd_data, rd_before);
    access(1'b1, 1'b0, 32'h08, 32'h0);
`ifdef DMEM_ERR_CHECK_EN
    check32("t6_ram2", mem_rd_data, 32'h0000_0011);
    check32("t6_err",  {31'd0, mem_err}, 32'd1);
`else
    check32("t6_ram2", mem_rd_data, 32'h0000_0055);
    check32("t6_err",  {31'd0, mem_err}, 32'd0);
`endif

    // Pattern sweep of stores then loads.
    for (int i = 0; i < 6; i++)
      access(1'b0, 1'b1, 32'h100 + 32'(i * 4), {16'(i), ~16'(i)} ^ 32'h5A5A_0000);
    for (int i = 5; i >= 0; i--)
      access(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
    check32("sweep_last", mem_rd_data, 32'h5A5A_FFFF);
    idle(1);
    check32("done_total", 32'(done_cnt), 32'(exp_done_cnt));

    // Final reset clears the sticky error.
    chk_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check32("final_err_clear", {31'd0, mem_err}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
